// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by on-chip RAM: single outstanding FIXED/INCR burst,
// ID-matched R/B responses, DECERR outside the window, SLVERR on bad bursts.
module axi_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  output logic        axi_awready_o,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  input  logic        axi_rready_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] WRESP = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [32:0] WIN_BYTES = 33'(1) << (ADDR_W + 2);

  logic [1:0]        state;
  logic              live;      // low for the first cycle out of reset so readies start at 0
  logic              prio_wr;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic              incr;
  logic              ram_ok;
  logic [1:0]        bresp_q;
  logic [1:0]        rresp_q;
  logic [3:0]        bid_q;
  logic [3:0]        rid_q;
  logic              rd_pending;

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic [31:0]       buf_data [2];
  logic [1:0]        buf_last;
  logic              wp;
  logic              rp;
  logic [1:0]        count;

  logic              aw_fire;
  logic              ar_fire;
  logic              w_fire;
  logic              r_fire;
  logic              rd_issue;
  logic [31:0]       a_addr;
  logic [1:0]        a_burst;
  logic [32:0]       a_off;
  logic [1:0]        a_resp;

  assign axi_awready_o = live && (state == IDLE) && !(axi_arvalid_i && !prio_wr);
  assign axi_arready_o = live && (state == IDLE) && !(axi_awvalid_i && prio_wr);
  assign axi_wready_o  = (state == WRITE);
  assign axi_bvalid_o  = (state == WRESP);
  assign axi_bresp_o   = bresp_q;
  assign axi_bid_o     = bid_q;
  assign axi_rid_o     = rid_q;
  assign axi_rvalid_o  = (count != 2'd0);
  assign axi_rdata_o   = axi_rvalid_o ? buf_data[rp] : '0;
  assign axi_rlast_o   = axi_rvalid_o && buf_last[rp];
  assign axi_rresp_o   = axi_rvalid_o ? rresp_q : OKAY;

  assign aw_fire  = axi_awvalid_i && axi_awready_o;
  assign ar_fire  = axi_arvalid_i && axi_arready_o;
  assign w_fire   = axi_wvalid_i && axi_wready_o;
  assign r_fire   = axi_rvalid_o && axi_rready_i;
  // A RAM read may issue into a slot that the current R handshake is freeing.
  assign rd_issue = (state == READ) && rd_pending && ((count != 2'd2) || axi_rready_i);

  // Decode the start address of whichever address channel is being accepted.
  always_comb begin
    a_addr  = aw_fire ? axi_awaddr_i  : axi_araddr_i;
    a_burst = aw_fire ? axi_awburst_i : axi_arburst_i;
    a_off   = {1'b0, a_addr} - {1'b0, BASE_ADDR};
    if (a_off[32] || (a_off >= WIN_BYTES)) a_resp = DECERR;
    else if (a_burst[1])                   a_resp = SLVERR;
    else                                   a_resp = OKAY;
  end

  // Transaction FSM, burst bookkeeping and output-buffer pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      live       <= 1'b0;
      prio_wr    <= 1'b0;
      idx        <= '0;
      len        <= '0;
      beat       <= '0;
      incr       <= 1'b0;
      ram_ok     <= 1'b0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      bid_q      <= '0;
      rid_q      <= '0;
      rd_pending <= 1'b0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      count      <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_fire) begin
            state   <= WRITE;
            prio_wr <= 1'b0;
            bid_q   <= axi_awid_i;
            bresp_q <= a_resp;
            ram_ok  <= (a_resp == OKAY);
            idx     <= a_off[ADDR_W+1:2];
            len     <= axi_awlen_i;
            incr    <= (axi_awburst_i == 2'b01);
            beat    <= '0;
          end else if (ar_fire) begin
            state      <= READ;
            prio_wr    <= 1'b1;
            rid_q      <= axi_arid_i;
            rresp_q    <= a_resp;
            ram_ok     <= (a_resp == OKAY);
            idx        <= a_off[ADDR_W+1:2];
            len        <= axi_arlen_i;
            incr       <= (axi_arburst_i == 2'b01);
            beat       <= '0;
            rd_pending <= 1'b1;
          end
        end
        WRITE: begin
          if (w_fire) begin
            if ((axi_wlast_i != (beat == len)) && (bresp_q != DECERR)) bresp_q <= SLVERR;
            beat <= beat + 8'd1;
            if (incr) idx <= idx + ADDR_W'(1);
            if (beat == len) state <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bready_i) state <= IDLE;
        end
        default: begin
          if (rd_issue) begin
            beat <= beat + 8'd1;
            if (incr) idx <= idx + ADDR_W'(1);
            if (beat == len) rd_pending <= 1'b0;
          end
          if (r_fire && axi_rlast_o) state <= IDLE;
        end
      endcase
      if (rd_issue) wp <= ~wp;
      if (r_fire)   rp <= ~rp;
      count <= count + 2'(rd_issue) - 2'(r_fire);
    end
  end

  // RAM byte-lane writes and synchronous reads landing directly in the output buffer.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_fire && ram_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (axi_wstrb_i[b]) mem[idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
      end
    end
    if (rd_issue) begin
      buf_data[wp] <= ram_ok ? mem[idx] : '0;
      buf_last[wp] <= (beat == len);
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed plus randomized bench for axi_mem_responder with a word-map memory model.
module tb_axi_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned AW    = 14;
  localparam int unsigned WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rlast, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  always #5 clk = ~clk;

  axi_mem_responder #(.BASE_ADDR(BASE), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awid_i(awid),
    .axi_awlen_i(awlen), .axi_awburst_i(awburst), .axi_awready_o(awready),
    .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
    .axi_wlast_i(wlast), .axi_wready_o(wready),
    .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bid_o(bid), .axi_bready_i(bready),
    .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arid_i(arid),
    .axi_arlen_i(arlen), .axi_arburst_i(arburst), .axi_arready_o(arready),
    .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
    .axi_rid_o(rid), .axi_rlast_o(rlast), .axi_rready_i(rready)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [31:0] model [int unsigned];
  logic [31:0] wdq [$];
  logic [3:0]  wsq [$];
  int          w_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [1:0] burst);
    if (addr < BASE || addr >= BASE + 32'(4 * WORDS)) return 2'b11;
    if (burst[1]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] addr, input int unsigned k,
                                          input logic [1:0] burst);
    int unsigned w0;
    w0 = (addr - BASE) >> 2;
    return (burst == 2'b01) ? (w0 + k) % WORDS : w0 % WORDS;
  endfunction

  function automatic void merge(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    if (!model.exists(w) && s != 4'hF) return;
    cur = model.exists(w) ? model[w] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    model[w] = cur;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst);
    logic got;
    got = 1'b0;
    awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = awready;
      step();
    end
    awvalid = 1'b0;
    if (!got) check("aw_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst);
    logic got;
    got = 1'b0;
    araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = arready;
      step();
    end
    arvalid = 1'b0;
    if (!got) check("ar_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic w_phase(input int wlast_at);
    int unsigned k, guard;
    k = 0; guard = 0;
    while (k < wdq.size() && guard < 4000) begin
      guard++;
      if ($urandom_range(99) < w_gap) begin
        wvalid = 1'b0; step();
      end else begin
        wvalid = 1'b1; wdata = wdq[k]; wstrb = wsq[k]; wlast = (int'(k) == wlast_at);
        @(negedge clk);
        check("wready", {31'b0, wready}, 32'd1);
        if (!wready) break;
        k++;
        step();
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (k < wdq.size()) check("w_timeout", k, wdq.size());
  endtask

  task automatic b_phase(input logic [1:0] er, input logic [3:0] id,
                         output logic ar_after, output logic aw_after);
    int unsigned d;
    d = $urandom_range(2);
    bready = 1'b0;
    @(negedge clk);
    check("bvalid_next_cycle", {31'b0, bvalid}, 32'd1);
    check("wready_after_last", {31'b0, wready}, 32'd0);
    for (int unsigned i = 0; i < d; i++) begin
      step(); @(negedge clk);
      check("bvalid_hold", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    check("bresp", {30'b0, bresp}, {30'b0, er});
    check("bid", {28'b0, bid}, {28'b0, id});
    step(); bready = 1'b0;
    @(negedge clk);
    check("bvalid_after", {31'b0, bvalid}, 32'd0);
    ar_after = arready; aw_after = awready;
    step();
  endtask

  // mode 0: rready always 1, mode 1: 1,0,0 repeating, other: random
  task automatic r_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int mode, input int abort_at,
                         output logic ar_after, output logic aw_after);
    logic [1:0]  er;
    int unsigned k, cyc;
    logic        held, hl;
    logic [31:0] hd;
    er = exp_resp(addr, burst);
    k = 0; cyc = 0; held = 1'b0; hd = '0; hl = 1'b0;
    ar_after = 1'b0; aw_after = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    check("rvalid_t1", {31'b0, rvalid}, 32'd0);
    step();
    while (k <= len && cyc < 4000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 3 == 0);
        default: rready = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      if (cyc == 0)       check("rvalid_t2", {31'b0, rvalid}, 32'd1);
      else if (mode == 0) check("r_nobubble", {31'b0, rvalid}, 32'd1);
      if (held) begin
        check("r_hold_valid", {31'b0, rvalid}, 32'd1);
        check("r_hold_data", rdata, hd);
        check("r_hold_last", {31'b0, rlast}, {31'b0, hl});
      end
      if (abort_at >= 0 && int'(k) == abort_at && rvalid) begin
        rst_n = 1'b0;
        step();
        rready = 1'b0;
        return;
      end
      held = rvalid && !rready; hd = rdata; hl = rlast;
      if (rvalid && rready) begin
        check("rresp", {30'b0, rresp}, {30'b0, er});
        check("rid", {28'b0, rid}, {28'b0, id});
        check("rlast", {31'b0, rlast}, {31'b0, (k == len)});
        if (er != 2'b00) check("rdata_err", rdata, 32'h0);
        else if (model.exists(word_of(addr, k, burst)))
          check("rdata", rdata, model[word_of(addr, k, burst)]);
        k++;
      end
      step(); cyc++;
    end
    rready = 1'b0;
    if (k <= len) check("r_timeout", k, len + 1);
    @(negedge clk);
    check("rvalid_after", {31'b0, rvalid}, 32'd0);
    ar_after = arready; aw_after = awready;
    step();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                          input int wlast_at);
    logic [7:0] len;
    logic [1:0] er;
    logic       a, w;
    len = 8'(wdq.size() - 1);
    er  = exp_resp(addr, burst);
    if (er == 2'b00)
      for (int unsigned k = 0; k < wdq.size(); k++) merge(word_of(addr, k, burst), wdq[k], wsq[k]);
    if (er == 2'b00 && wlast_at != int'(len)) er = 2'b10;
    aw_phase(addr, id, len, burst);
    w_phase(wlast_at);
    b_phase(er, id, a, w);
    check("awready_after_b", {31'b0, w}, 32'd1);
    check("arready_after_b", {31'b0, a}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int mode);
    logic a, w;
    ar_phase(addr, id, len, burst);
    r_phase(addr, id, len, burst, mode, -1, a, w);
    check("arready_after_rlast", {31'b0, a}, 32'd1);
    check("awready_after_rlast", {31'b0, w}, 32'd1);
  endtask

  task automatic fill(input int unsigned n, input logic [31:0] start, input logic seq);
    wdq.delete(); wsq.delete();
    for (int unsigned k = 0; k < n; k++) begin
      wdq.push_back(seq ? start + k : $urandom);
      wsq.push_back(4'hF);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, w;

    // Reset values
    step(); step();
    @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rlast", {31'b0, rlast}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    check("rst_ids", {24'b0, bid, rid}, 32'd0);
    rst_n = 1'b1;
    step();

    // Preload words 0..71 with random data
    fill(72, 0, 1'b0);
    do_write(BASE, 4'd1, 2'b01, 71);

    // Single write then read
    wdq = {32'hDEAD_BEEF}; wsq = {4'hF};
    do_write(32'h8000_0010, 4'd3, 2'b01, 0);
    do_read(32'h8000_0010, 4'd5, 8'd0, 2'b01, 0);

    // Words 0..7 hold k; read with backpressure then with rready held
    fill(8, 0, 1'b1);
    do_write(BASE, 4'd2, 2'b01, 7);
    do_read(BASE, 4'd6, 8'd7, 2'b01, 1);
    do_read(BASE, 4'd7, 8'd7, 2'b01, 0);

    // Byte strobes
    wdq = {32'h1122_3344}; wsq = {4'hF};
    do_write(BASE + 32'h50, 4'd4, 2'b01, 0);
    wdq = {32'hAABB_CCDD}; wsq = {4'b0101};
    do_write(BASE + 32'h50, 4'd4, 2'b01, 0);
    check("strobe_model", model[20], 32'h11BB_33DD);
    do_read(BASE + 32'h50, 4'd8, 8'd0, 2'b01, 0);

    // Errors
    do_read(32'h0000_1000, 4'd9, 8'd3, 2'b01, 0);
    do_read(32'h0000_1000, 4'd9, 8'd0, 2'b10, 2);
    do_read(BASE + 32'h1_0000, 4'd1, 8'd0, 2'b01, 0);
    do_read(BASE - 32'd4, 4'd1, 8'd1, 2'b00, 0);
    fill(2, 32'hFFFF_0000, 1'b1);
    do_write(BASE, 4'd10, 2'b10, 1);
    do_read(BASE, 4'd11, 8'd1, 2'b01, 0);
    fill(3, 32'hC0DE_0000, 1'b1);
    do_write(BASE + 32'h100, 4'd12, 2'b01, 1);
    do_read(BASE + 32'h100, 4'd13, 8'd2, 2'b01, 2);

    // Index wraps at the top of the RAM; FIXED burst reads one word repeatedly
    fill(6, 32'h7700_0000, 1'b1);
    do_write(BASE + 32'(4 * (WORDS - 2)), 4'd14, 2'b01, 5);
    do_read(BASE + 32'(4 * (WORDS - 2)), 4'd15, 8'd5, 2'b01, 0);
    do_read(BASE + 32'h0_FFFC, 4'd15, 8'd0, 2'b01, 0);
    do_read(BASE + 32'h8, 4'd3, 8'd3, 2'b00, 1);

    // Arbitration: tie after reset goes to read, next tie to the write
    pulse_reset();
    wdq = {32'h5A5A_0001}; wsq = {4'hF};
    awaddr = BASE + 32'h200; awid = 4'd7; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    araddr = BASE; arid = 4'd2; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("tie1_arready", {31'b0, arready}, 32'd1);
    check("tie1_awready", {31'b0, awready}, 32'd0);
    step();
    araddr = BASE + 32'h200; arid = 4'd9; arlen = 8'd0; arburst = 2'b01;
    r_phase(BASE, 4'd2, 8'd1, 2'b01, 0, -1, a, w);
    check("tie2_awready", {31'b0, w}, 32'd1);
    check("tie2_arready", {31'b0, a}, 32'd0);
    awvalid = 1'b0;
    merge(128, 32'h5A5A_0001, 4'hF);
    w_phase(0);
    b_phase(2'b00, 4'd7, a, w);
    check("pending_ar_granted", {31'b0, a}, 32'd1);
    arvalid = 1'b0;
    r_phase(BASE + 32'h200, 4'd9, 8'd0, 2'b01, 0, -1, a, w);

    // Reset during beat 3 of a 16-beat read
    fill(16, 0, 1'b0);
    do_write(BASE + 32'h80, 4'd1, 2'b01, 15);
    ar_phase(BASE + 32'h80, 4'd6, 8'd15, 2'b01);
    r_phase(BASE + 32'h80, 4'd6, 8'd15, 2'b01, 0, 3, a, w);
    @(negedge clk);
    check("midrst_valids", {29'b0, rvalid, bvalid, wready}, 32'd0);
    check("midrst_readies", {30'b0, arready, awready}, 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("midrst_idle", {30'b0, arready, awready}, 32'd3);
    step();
    do_read(BASE + 32'h80, 4'd6, 8'd15, 2'b01, 0);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [7:0]  len;
      int          wl;
      if ($urandom_range(9) == 0)
        addr = $urandom_range(1) ? BASE - 32'(4 * ($urandom_range(15) + 1))
                                 : BASE + 32'h1_0000 + 32'(4 * $urandom_range(15));
      else
        addr = BASE + 32'(4 * $urandom_range(63)) + 32'($urandom_range(3));
      burst = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1));
      len   = 8'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        wdq.delete(); wsq.delete();
        for (int k = 0; k <= int'(len); k++) begin
          wdq.push_back($urandom);
          wsq.push_back(4'($urandom));
        end
        wl = ($urandom_range(9) == 0) ? int'($urandom_range(len)) : int'(len);
        w_gap = int'($urandom_range(30));
        do_write(addr, 4'($urandom), burst, wl);
        w_gap = 0;
      end else begin
        do_read(addr, 4'($urandom), len, burst, 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
